tx_burst_arbiter: RTL and testbench
===================================

# tx_burst_arbiter

Shares the single UART Transmitter between two burst requesters: channel A carries minimization result words, and channel B carries error/status words. It grants one channel at a time using round-robin and locks the grant for a whole burst, so frames from the two channels never interleave. Words go to the Transmitter one at a time with a one-cycle `tx_send` pulse, and the arbiter waits for the Transmitter's `tx_ready` completion pulse between words. A watchdog aborts a burst if the Transmitter stalls.

## Interface
- `DW`, default 10: data word width (result word width).
- `CW`, default 6: burst length and word counter width.
- `TO`, default 65535: watchdog limit, in cycles spent in WAIT without `tx_ready`. Minimum 1.
- `clk` in 1: the only clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `a_req` in 1: channel A requests a burst. Level signal, held until `a_done` or `abort`.
- `a_len` in CW: number of words in A's burst. Sampled only in GRANT.
- `a_data` in DW: A's current word. Must be valid whenever `a_req` is high.
- `a_next` out 1: one-cycle pulse meaning A's current word was sent. A presents its next word on the following cycle.
- `a_done` out 1: one-cycle pulse meaning A's burst completed.
- `b_req`, `b_len`, `b_data`, `b_next`, `b_done`: same as channel A, for channel B.
- `tx_data` out DW: word driven to the Transmitter. Stable from the `tx_send` cycle until `tx_ready`.
- `tx_src` out 1: source of the current word. 0 = A, 1 = B. The Transmitter uses it as its error-frame flag.
- `tx_send` out 1: one-cycle start pulse to the Transmitter.
- `tx_ready` in 1: pulse from the Transmitter meaning the current word is finished.
- `busy` out 1: high in every state except IDLE.
- `abort` out 1: one-cycle pulse when the watchdog fires.

## Operation
- States: IDLE, GRANT, LOAD, WAIT, NEXT, DONE.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that channel.
  - Both requests: grant the channel other than `last`.
  - Register `gnt`, go to GRANT.
- GRANT: latch `len` from the granted channel and clear `cnt`.
  - `len`==0: go to DONE with no transmission.
  - Otherwise go to LOAD.
- LOAD: register `tx_data` from the granted channel's data, set `tx_src`=`gnt`, pulse `tx_send`, clear the watchdog, go to WAIT.
- WAIT:
  - `tx_ready`=1: go to NEXT.
  - Otherwise increment the watchdog.
  - Watchdog reaches `TO`: pulse `abort`, set `last`=`gnt`, go to IDLE. No `next` or `done` pulse is issued for the burst.
- NEXT: pulse `next` on the granted channel and increment `cnt` (CW bits).
  - `cnt`+1 == `len`: go to DONE.
  - Otherwise go to LOAD.
- DONE: pulse `done` on the granted channel, set `last`=`gnt`, go to IDLE.
- Grant lock: changes on either `req` line between GRANT and DONE are ignored. The ungranted channel waits.
- `tx_ready` is ignored in every state except WAIT.
- Reset values:
  - state = IDLE, `last` = 1 (so A wins the first tie).
  - `gnt`, `cnt`, `len`, watchdog = 0.
  - All outputs, including `tx_data`, = 0.
- Reset mid-burst: return to IDLE immediately. No `done`, `next` or `abort` pulse is issued.
  - A Transmitter already running completes on its own.
  - Its `tx_ready` pulse is ignored.
- Burst length range: `len` up to 2^CW−1. `cnt` never wraps, because the comparison ends the burst first.

## Timing
- `req` sampled high at edge E0 (state IDLE):
  - GRANT after E0, LOAD after E1.
  - `tx_send`=1 and `tx_data` valid in the cycle after E2.
- The data word is sampled at the LOAD edge. A requester must present its next word no later than the cycle after its `next` pulse.
- `tx_ready` high at edge Em:
  - `next` pulse in the cycle after Em.
  - LOAD at Em+1, then the next `tx_send` in the cycle after Em+2.
  - The minimum gap between `tx_send` pulses is therefore 3 cycles plus the Transmitter time.
- Last word: `done` pulses in the cycle after Em+1, and the state is IDLE after Em+2.
- `len`=0: `done` pulses 2 cycles after grant with no `tx_send`.
- Re-arbitration takes 1 cycle. A requester that keeps `req` high after its own `done` loses to a pending request from the other channel.
- Watchdog: `abort` pulses `TO` cycles after `tx_send`, counting only WAIT cycles.

## Test plan
- A only, `len`=3, data 0x011/0x022/0x033, Transmitter model answering `tx_ready` 5 cycles after each `tx_send` -> three `tx_send` pulses carrying those words with `tx_src`=0, three `a_next` pulses, one `a_done`. Check: `busy` drops 2 cycles after `a_done`.
- A and B raised in the same cycle right after reset, both `len`=1 -> A is served first, then B. `b_done` follows `a_done`. A re-raised immediately after its burst waits behind B.
- B granted with `len`=4; A raised after B's second word -> no A word appears until `b_done`. A's `tx_send` then arrives within 3 cycles.
- `len`=0 on A -> `a_done` with no `tx_send` and no `a_next`.
- `TO`=8, Transmitter never asserts `tx_ready` -> `abort` 8 cycles after `tx_send`, no `a_done`, state back to IDLE. A spurious `tx_ready` arriving afterwards has no effect.
- `rst` asserted in WAIT of word 2 of 3 -> all outputs 0 on the next cycle, no `done` pulse. A fresh request is served normally with A winning the first tie.

Source files
------------

// File: rtl/tx_burst_arbiter_if.sv
// Bundle between the two burst requesters, the UART Transmitter and the
// burst arbiter. The master modport is the arbiter's view; the slave
// modport is the view of everything around it (requesters and Transmitter).
interface tx_burst_arbiter_if #(
    parameter int DW = 10,
    parameter int CW = 6
);
    logic          a_req;
    logic [CW-1:0] a_len;
    logic [DW-1:0] a_data;
    logic          a_next;
    logic          a_done;

    logic          b_req;
    logic [CW-1:0] b_len;
    logic [DW-1:0] b_data;
    logic          b_next;
    logic          b_done;

    logic [DW-1:0] tx_data;
    logic          tx_src;
    logic          tx_send;
    logic          tx_ready;

    logic          busy;
    logic          abort;

    modport master (
        input  a_req, a_len, a_data, b_req, b_len, b_data, tx_ready,
        output a_next, a_done, b_next, b_done, tx_data, tx_src, tx_send,
               busy, abort
    );

    modport slave (
        output a_req, a_len, a_data, b_req, b_len, b_data, tx_ready,
        input  a_next, a_done, b_next, b_done, tx_data, tx_src, tx_send,
               busy, abort
    );
endinterface

// File: rtl/tx_burst_arbiter.sv
// Round-robin burst arbiter sharing one UART Transmitter between channel A
// (result words) and channel B (error/status words). A grant is held for a
// whole burst; words are sent one at a time and a watchdog aborts a burst
// whose Transmitter never reports completion.
module tx_burst_arbiter #(
    parameter int DW = 10,
    parameter int CW = 6,
    parameter int TO = 65535
) (
    input  logic               clk,
    input  logic               rst,
    tx_burst_arbiter_if.master bus
);

    // Watchdog only has to count 0 .. TO-1 before it fires.
    localparam int WW = (TO < 2) ? 1 : $clog2(TO);
    localparam logic [WW-1:0] WD_LAST = WW'(TO - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t        state_r;
    state_t        state_s;

    logic          gnt_r;
    logic          last_r;
    logic          gnt_sel_s;
    logic [CW-1:0] len_r;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_inc_s;
    logic [CW-1:0] len_sel_s;
    logic [WW-1:0] wd_r;
    logic          wd_hit_s;

    logic [DW-1:0] tx_data_r;
    logic          tx_src_r;
    logic          tx_send_r;
    logic          tx_send_s;
    logic          a_next_r;
    logic          a_next_s;
    logic          a_done_r;
    logic          a_done_s;
    logic          b_next_r;
    logic          b_next_s;
    logic          b_done_r;
    logic          b_done_s;
    logic          busy_r;
    logic          busy_s;
    logic          abort_r;
    logic          abort_s;

    assign cnt_inc_s = cnt_r + CW'(1'b1);
    assign wd_hit_s  = (wd_r == WD_LAST);

    // Round-robin pick and the burst length of the granted channel.
    always_comb begin
        gnt_sel_s = 1'b0;
        if (bus.a_req && bus.b_req) begin
            gnt_sel_s = ~last_r;
        end else if (bus.a_req) begin
            gnt_sel_s = 1'b0;
        end else begin
            gnt_sel_s = 1'b1;
        end
        if (gnt_r) begin
            len_sel_s = bus.b_len;
        end else begin
            len_sel_s = bus.a_len;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; request lines are only looked at in IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    state_s = ST_GRANT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (len_sel_s == {CW{1'b0}}) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.tx_ready) begin
                    state_s = ST_NEXT;
                end else if (wd_hit_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_NEXT: begin
                if (cnt_inc_s == len_r) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs, so each pulse lines up with
    // the state it belongs to.
    always_comb begin
        tx_send_s = (state_r == ST_LOAD);
        a_next_s  = (state_s == ST_NEXT) && !gnt_r;
        b_next_s  = (state_s == ST_NEXT) &&  gnt_r;
        a_done_s  = (state_s == ST_DONE) && !gnt_r;
        b_done_s  = (state_s == ST_DONE) &&  gnt_r;
        abort_s   = (state_r == ST_WAIT) && !bus.tx_ready && wd_hit_s;
        busy_s    = (state_r != ST_IDLE);
    end

    // Burst datapath: grant, round-robin history, length, word count,
    // watchdog and the word held for the Transmitter.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_r     <= 1'b0;
            last_r    <= 1'b1;
            len_r     <= {CW{1'b0}};
            cnt_r     <= {CW{1'b0}};
            wd_r      <= {WW{1'b0}};
            tx_data_r <= {DW{1'b0}};
            tx_src_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (state_s == ST_GRANT) begin
                        gnt_r <= gnt_sel_s;
                    end
                end
                ST_GRANT: begin
                    len_r <= len_sel_s;
                    cnt_r <= {CW{1'b0}};
                end
                ST_LOAD: begin
                    tx_data_r <= gnt_r ? bus.b_data : bus.a_data;
                    tx_src_r  <= gnt_r;
                    wd_r      <= {WW{1'b0}};
                end
                ST_WAIT: begin
                    if (abort_s) begin
                        last_r <= gnt_r;
                    end else if (!bus.tx_ready) begin
                        wd_r <= wd_r + WW'(1'b1);
                    end
                end
                ST_NEXT: begin
                    cnt_r <= cnt_inc_s;
                end
                ST_DONE: begin
                    last_r <= gnt_r;
                end
                default: begin
                end
            endcase
        end
    end

    // Output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_send_r <= 1'b0;
            a_next_r  <= 1'b0;
            b_next_r  <= 1'b0;
            a_done_r  <= 1'b0;
            b_done_r  <= 1'b0;
            abort_r   <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            tx_send_r <= tx_send_s;
            a_next_r  <= a_next_s;
            b_next_r  <= b_next_s;
            a_done_r  <= a_done_s;
            b_done_r  <= b_done_s;
            abort_r   <= abort_s;
            busy_r    <= busy_s;
        end
    end

    assign bus.tx_data = tx_data_r;
    assign bus.tx_src  = tx_src_r;
    assign bus.tx_send = tx_send_r;
    assign bus.a_next  = a_next_r;
    assign bus.a_done  = a_done_r;
    assign bus.b_next  = b_next_r;
    assign bus.b_done  = b_done_r;
    assign bus.busy    = busy_r;
    assign bus.abort   = abort_r;

endmodule

// File: tb/tb_tx_burst_arbiter.sv
// Directed bench for tx_burst_arbiter: requester and Transmitter models run
// inside the per-cycle tick task; sent words are checked against a queue of
// expected {src,data} words filled when each request is raised.
module tb_tx_burst_arbiter;

    localparam int DW = 10;
    localparam int CW = 6;
    localparam int TO = 8;

    logic clk;
    logic rst;

    tx_burst_arbiter_if #(.DW(DW), .CW(CW)) bus ();

    tx_burst_arbiter #(.DW(DW), .CW(CW), .TO(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_cmp;
    int            n_fail;
    int            cyc;
    logic [DW:0]   exp_q[$];
    logic [DW-1:0] a_words[16];
    logic [DW-1:0] b_words[16];
    int            a_idx;
    int            b_idx;
    int            n_send, n_anext, n_bnext, n_adone, n_bdone, n_abort;
    int            send_cyc, adone_cyc, bdone_cyc, abort_cyc;
    int            rdy_cnt;
    bit            tx_silent;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] outs_vec();
        return {14'd0, bus.tx_data, bus.tx_src, bus.tx_send, bus.a_next, bus.a_done,
                bus.b_next, bus.b_done, bus.busy, bus.abort};
    endfunction

    // One clock: observe outputs at the falling edge, run the models, drive inputs.
    task automatic tick();
        logic [DW:0] exp_w;
        @(negedge clk);
        cyc++;
        bus.tx_ready = 1'b0;
        if (rdy_cnt > 0) begin
            rdy_cnt--;
            if (rdy_cnt == 0) bus.tx_ready = 1'b1;
        end
        if (bus.tx_send) begin
            n_send++;
            send_cyc = cyc;
            check("tx_word_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                exp_w = exp_q.pop_front();
                check("tx_word", 32'({bus.tx_src, bus.tx_data}), 32'(exp_w));
            end
            if (!tx_silent) rdy_cnt = 5;
        end
        if (bus.a_next) begin n_anext++; a_idx++; end
        if (bus.b_next) begin n_bnext++; b_idx++; end
        if (bus.a_done) begin n_adone++; adone_cyc = cyc; bus.a_req = 1'b0; end
        if (bus.b_done) begin n_bdone++; bdone_cyc = cyc; bus.b_req = 1'b0; end
        if (bus.abort) begin
            n_abort++;
            abort_cyc = cyc;
            bus.a_req = 1'b0;
            bus.b_req = 1'b0;
        end
        bus.a_data = a_words[a_idx % 16];
        bus.b_data = b_words[b_idx % 16];
    endtask

    initial begin
        int s0, an0, bn0, ad0, bd0, ab0, r0;
        n_cmp = 0; n_fail = 0; cyc = 0;
        n_send = 0; n_anext = 0; n_bnext = 0; n_adone = 0; n_bdone = 0; n_abort = 0;
        send_cyc = 0; adone_cyc = 0; bdone_cyc = 0; abort_cyc = 0;
        rdy_cnt = 0; tx_silent = 1'b0; a_idx = 0; b_idx = 0;
        for (int i = 0; i < 16; i++) begin a_words[i] = '0; b_words[i] = '0; end
        rst = 1'b1;
        bus.a_req = 1'b0; bus.a_len = '0; bus.a_data = '0;
        bus.b_req = 1'b0; bus.b_len = '0; bus.b_data = '0;
        bus.tx_ready = 1'b0;

        // Reset state.
        repeat (3) tick();
        check("reset_outputs", outs_vec(), 32'd0);
        rst = 1'b0;
        tick();

        // Tie right after reset: A first, then B; A re-raised waits behind B.
        a_words[0] = 10'h0AA; a_words[1] = 10'h0CC; b_words[0] = 10'h2BB;
        a_idx = 0; b_idx = 0; bus.a_len = 6'd1; bus.b_len = 6'd1;
        exp_q.push_back({1'b0, 10'h0AA});
        exp_q.push_back({1'b1, 10'h2BB});
        ad0 = n_adone; bd0 = n_bdone;
        bus.a_req = 1'b1; bus.b_req = 1'b1;
        for (int i = 0; i < 100 && n_adone == ad0; i++) tick();
        check("tie_a_done", n_adone - ad0, 1);
        check("tie_b_not_first", n_bdone - bd0, 0);
        bus.a_req = 1'b1;
        exp_q.push_back({1'b0, 10'h0CC});
        for (int i = 0; i < 100 && n_bdone == bd0; i++) tick();
        check("tie_b_done", n_bdone - bd0, 1);
        for (int i = 0; i < 100 && n_adone == ad0 + 1; i++) tick();
        check("tie_a_again_done", n_adone - ad0, 2);
        check("tie_a_after_b", 32'(adone_cyc > bdone_cyc), 32'd1);
        check("tie_queue_empty", exp_q.size(), 0);

        // A alone, three words.
        repeat (3) tick();
        a_words[0] = 10'h011; a_words[1] = 10'h022; a_words[2] = 10'h033;
        a_idx = 0; bus.a_len = 6'd3;
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, a_words[i]});
        s0 = n_send; an0 = n_anext; ad0 = n_adone; r0 = cyc;
        bus.a_req = 1'b1;
        for (int i = 0; i < 100 && n_send == s0; i++) tick();
        check("a3_first_send_latency", send_cyc - r0, 3);
        for (int i = 0; i < 200 && n_adone == ad0; i++) tick();
        check("a3_sends", n_send - s0, 3);
        check("a3_nexts", n_anext - an0, 3);
        check("a3_dones", n_adone - ad0, 1);
        check("a3_queue_empty", exp_q.size(), 0);
        tick();
        check("a3_busy_done_plus1", 32'(bus.busy), 32'd1);
        tick();
        check("a3_busy_done_plus2", 32'(bus.busy), 32'd0);

        // B holds the grant for four words; A raised mid-burst waits.
        repeat (3) tick();
        b_words[0] = 10'h101; b_words[1] = 10'h102; b_words[2] = 10'h103; b_words[3] = 10'h104;
        b_idx = 0; bus.b_len = 6'd4;
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, b_words[i]});
        s0 = n_send; bn0 = n_bnext; bd0 = n_bdone; ad0 = n_adone;
        bus.b_req = 1'b1;
        for (int i = 0; i < 200 && n_bnext < bn0 + 2; i++) tick();
        a_words[0] = 10'h055; a_idx = 0; bus.a_len = 6'd1;
        exp_q.push_back({1'b0, 10'h055});
        bus.a_req = 1'b1;
        for (int i = 0; i < 200 && n_bdone == bd0; i++) tick();
        check("lock_sends_at_b_done", n_send - s0, 4);
        for (int i = 0; i < 100 && n_send < s0 + 5; i++) tick();
        // IDLE follows done by one cycle; a new word is then 3 cycles away.
        check("lock_a_send_after_idle", send_cyc - (bdone_cyc + 1), 3);
        for (int i = 0; i < 100 && n_adone == ad0; i++) tick();
        check("lock_a_done", n_adone - ad0, 1);
        check("lock_queue_empty", exp_q.size(), 0);

        // Zero-length burst.
        repeat (3) tick();
        bus.a_len = 6'd0;
        s0 = n_send; an0 = n_anext; ad0 = n_adone; r0 = cyc;
        bus.a_req = 1'b1;
        for (int i = 0; i < 50 && n_adone == ad0; i++) tick();
        check("len0_done_latency", adone_cyc - r0, 2);
        check("len0_no_send", n_send - s0, 0);
        check("len0_no_next", n_anext - an0, 0);

        // Stalled Transmitter: watchdog abort.
        repeat (3) tick();
        tx_silent = 1'b1;
        a_words[0] = 10'h3FF; a_idx = 0; bus.a_len = 6'd1;
        exp_q.push_back({1'b0, 10'h3FF});
        s0 = n_send; an0 = n_anext; ad0 = n_adone; ab0 = n_abort;
        bus.a_req = 1'b1;
        for (int i = 0; i < 100 && n_abort == ab0; i++) tick();
        check("wd_abort_count", n_abort - ab0, 1);
        check("wd_abort_delay", abort_cyc - send_cyc, TO);
        check("wd_no_done", n_adone - ad0, 0);
        tick();
        check("wd_idle_busy", 32'(bus.busy), 32'd0);
        bus.tx_ready = 1'b1;
        repeat (5) tick();
        check("wd_spurious_ready_next", n_anext - an0, 0);
        check("wd_spurious_ready_done", n_adone - ad0, 0);
        check("wd_spurious_ready_send", n_send - s0, 1);
        check("wd_spurious_ready_busy", 32'(bus.busy), 32'd0);
        tx_silent = 1'b0;

        // Reset during WAIT of word 2 of 3, then a fresh tie.
        repeat (3) tick();
        a_words[0] = 10'h111; a_words[1] = 10'h122; a_words[2] = 10'h133;
        a_idx = 0; bus.a_len = 6'd3;
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, a_words[i]});
        s0 = n_send;
        bus.a_req = 1'b1;
        for (int i = 0; i < 200 && n_send < s0 + 2; i++) tick();
        check("rst_mid_reached_word2", n_send - s0, 2);
        rst = 1'b1;
        an0 = n_anext; ad0 = n_adone; ab0 = n_abort;
        tick();
        check("rst_mid_outputs", outs_vec(), 32'd0);
        rst = 1'b0;
        bus.a_req = 1'b0;
        exp_q.delete();
        repeat (8) tick();
        check("rst_mid_no_next", n_anext - an0, 0);
        check("rst_mid_no_done", n_adone - ad0, 0);
        check("rst_mid_no_abort", n_abort - ab0, 0);
        check("rst_mid_idle", 32'(bus.busy), 32'd0);
        a_words[0] = 10'h1A1; b_words[0] = 10'h2B2;
        a_idx = 0; b_idx = 0; bus.a_len = 6'd1; bus.b_len = 6'd1;
        exp_q.push_back({1'b0, 10'h1A1});
        exp_q.push_back({1'b1, 10'h2B2});
        bd0 = n_bdone; ad0 = n_adone;
        bus.a_req = 1'b1; bus.b_req = 1'b1;
        for (int i = 0; i < 200 && n_bdone == bd0; i++) tick();
        check("rst_fresh_b_done", n_bdone - bd0, 1);
        check("rst_fresh_a_done", n_adone - ad0, 1);
        check("rst_fresh_a_first", 32'(adone_cyc < bdone_cyc), 32'd1);
        check("rst_fresh_queue_empty", exp_q.size(), 0);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
